// File: rtl/cache_ctrl_assoc.sv
// rtl/cache_ctrl_assoc.sv - write-back, write-allocate 1/2-way cache controller
module cache_ctrl_assoc #(
    parameter int  AW         = 16,
    parameter int  DW         = 16,
    parameter int  WAYS       = 2,
    parameter int  INDEX_W    = 8,
    parameter int  LINE_WORDS = 4,
    parameter int  MEM_LAT    = 2,
    localparam int WORD_W     = $clog2(LINE_WORDS),
    localparam int OFF_W      = WORD_W + 1,
    localparam int TAG_W      = AW - INDEX_W - OFF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         Addr,
    input  logic [DW-1:0]         DataIn,
    input  logic                  Rd,
    input  logic                  Wr,
    output logic [DW-1:0]         DataOut,
    output logic                  Done,
    output logic                  Stall,
    output logic                  CacheHit,
    output logic                  err,
    output logic [WAYS-1:0]       c_en,
    output logic                  c_comp,
    output logic                  c_write,
    output logic                  c_valid_in,
    output logic [OFF_W-1:0]      c_offset,
    output logic [DW-1:0]         c_data_in,
    input  logic [WAYS*TAG_W-1:0] c_tag_out,
    input  logic [WAYS*DW-1:0]    c_data_out,
    input  logic [WAYS-1:0]       c_hit,
    input  logic [WAYS-1:0]       c_dirty,
    input  logic [WAYS-1:0]       c_valid,
    input  logic                  c_err,
    output logic [AW-1:0]         m_addr,
    output logic [DW-1:0]         m_data_in,
    output logic                  m_rd,
    output logic                  m_wr,
    input  logic [DW-1:0]         m_data_out,
    input  logic                  m_stall,
    input  logic                  m_err
);

    localparam int CNT_W = WORD_W + 1;
    localparam int SETS  = 2 ** INDEX_W;

    typedef enum logic [2:0] {IDLE, COMP, WB, FILL, RECOMP, DONE} state_t;
    state_t state, state_nx;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic               op_wr;
    logic               victim, victim_nx;
    logic               hit_way, any_hit;
    logic [WAYS-1:0]    hit_vec;
    logic [WAYS-1:0]    victim_oh;
    logic [TAG_W-1:0]   victim_tag;
    logic [DW-1:0]      victim_data, hit_data;
    logic [CNT_W-1:0]   wb_cnt, issue_cnt, ret_cnt;
    logic [MEM_LAT-1:0] ret_sr;
    logic               ret_valid, rd_accept;
    logic [SETS-1:0]    lru;
    logic [DW-1:0]      data_out_q;
    logic               hit_q;

    assign req_tag   = Addr[AW-1 -: TAG_W];
    assign req_index = Addr[OFF_W +: INDEX_W];
    assign rd_accept = m_rd & ~m_stall;
    assign ret_valid = ret_sr[MEM_LAT-1];

    assign Done     = (state == DONE);
    assign Stall    = (state != IDLE) && (state != DONE);
    assign CacheHit = Done & hit_q;
    assign DataOut  = Done ? data_out_q : '0;
    assign err      = c_err | m_err | ((state == IDLE) & Rd & Wr);

    // Way lookup: hit way, victim choice (first invalid way, else LRU) and selected way data
    always_comb begin
        hit_vec   = c_valid & c_hit;
        any_hit   = |hit_vec;
        hit_way   = 1'b0;
        victim_nx = (WAYS == 2) ? lru[req_index] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])  hit_way   = w[0];
            if (!c_valid[w]) victim_nx = w[0];
        end
        victim_oh   = WAYS'(1) << victim;
        victim_tag  = c_tag_out[int'(victim) * TAG_W +: TAG_W];
        victim_data = c_data_out[int'(victim) * DW +: DW];
        hit_data    = c_data_out[int'(hit_way) * DW +: DW];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and array/memory sequencing
    always_comb begin
        state_nx   = state;
        c_en       = '0;
        c_comp     = 1'b0;
        c_write    = 1'b0;
        c_valid_in = 1'b0;
        c_offset   = '0;
        c_data_in  = '0;
        m_addr     = '0;
        m_data_in  = '0;
        m_rd       = 1'b0;
        m_wr       = 1'b0;
        case (state)
            IDLE: begin
                if (Rd ^ Wr) state_nx = COMP;
            end
            COMP: begin
                c_en      = '1;
                c_comp    = 1'b1;
                c_write   = op_wr;
                c_offset  = Addr[OFF_W-1:0];
                c_data_in = DataIn;
                if (any_hit)                                      state_nx = DONE;
                else if (c_valid[victim_nx] && c_dirty[victim_nx]) state_nx = WB;
                else                                              state_nx = FILL;
            end
            WB: begin
                c_en      = victim_oh;
                c_offset  = {wb_cnt[WORD_W-1:0], 1'b0};
                m_wr      = 1'b1;
                m_addr    = {victim_tag, req_index, wb_cnt[WORD_W-1:0], 1'b0};
                m_data_in = victim_data;
                if (!m_stall && wb_cnt == CNT_W'(LINE_WORDS - 1)) state_nx = FILL;
            end
            FILL: begin
                m_rd   = (issue_cnt < CNT_W'(LINE_WORDS));
                m_addr = {req_tag, req_index, issue_cnt[WORD_W-1:0], 1'b0};
                if (ret_valid) begin
                    c_en       = victim_oh;
                    c_write    = 1'b1;
                    c_valid_in = 1'b1;
                    c_offset   = {ret_cnt[WORD_W-1:0], 1'b0};
                    c_data_in  = m_data_out;
                    if (ret_cnt == CNT_W'(LINE_WORDS - 1)) state_nx = RECOMP;
                end
            end
            RECOMP: begin
                c_en      = victim_oh;
                c_comp    = 1'b1;
                c_write   = op_wr;
                c_offset  = Addr[OFF_W-1:0];
                c_data_in = DataIn;
                state_nx  = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request op, victim, word counters, return tracking, LRU and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr      <= 1'b0;
            victim     <= 1'b0;
            wb_cnt     <= '0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            ret_sr     <= '0;
            lru        <= '0;
            data_out_q <= '0;
            hit_q      <= 1'b0;
        end else begin
            ret_sr <= MEM_LAT'({ret_sr, rd_accept});
            case (state)
                IDLE: begin
                    if (Rd ^ Wr) op_wr <= Wr;
                end
                COMP: begin
                    victim    <= victim_nx;
                    wb_cnt    <= '0;
                    issue_cnt <= '0;
                    ret_cnt   <= '0;
                    hit_q     <= any_hit;
                    if (any_hit) begin
                        data_out_q <= hit_data;
                        if (WAYS == 2) lru[req_index] <= ~hit_way;
                    end
                end
                WB: begin
                    if (!m_stall) wb_cnt <= wb_cnt + 1'b1;
                end
                FILL: begin
                    if (rd_accept) issue_cnt <= issue_cnt + 1'b1;
                    if (ret_valid) ret_cnt   <= ret_cnt + 1'b1;
                end
                RECOMP: begin
                    data_out_q <= victim_data;
                    hit_q      <= 1'b0;
                    if (WAYS == 2) lru[req_index] <= ~victim;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// tb/tb_cache_ctrl_assoc.sv - scoreboard bench for cache_ctrl_assoc with array and memory models
module tb_cache_ctrl_assoc;

    localparam int AW = 16, DW = 16, WAYS = 2, INDEX_W = 8, LINE_WORDS = 4, MEM_LAT = 2;
    localparam int OFF_W = 3, TAG_W = 5;

    logic clk, rst;
    logic [AW-1:0] Addr;
    logic [DW-1:0] DataIn, DataOut;
    logic Rd, Wr, Done, Stall, CacheHit, err;
    logic [WAYS-1:0] c_en, c_hit, c_dirty, c_valid;
    logic c_comp, c_write, c_valid_in, c_err;
    logic [OFF_W-1:0] c_offset;
    logic [DW-1:0] c_data_in;
    logic [WAYS*TAG_W-1:0] c_tag_out;
    logic [WAYS*DW-1:0] c_data_out;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data_in, m_data_out;
    logic m_rd, m_wr, m_stall, m_err;
    logic arr_clr;

    cache_ctrl_assoc #(.AW(AW), .DW(DW), .WAYS(WAYS), .INDEX_W(INDEX_W),
                       .LINE_WORDS(LINE_WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .c_en(c_en), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
        .c_offset(c_offset), .c_data_in(c_data_in), .c_tag_out(c_tag_out),
        .c_data_out(c_data_out), .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid),
        .c_err(c_err), .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
        .m_data_out(m_data_out), .m_stall(m_stall), .m_err(m_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- external tag/data array model ----------------
    logic [TAG_W-1:0] a_tag  [WAYS][256];
    logic             a_val  [WAYS][256];
    logic             a_dty  [WAYS][256];
    logic [DW-1:0]    a_data [WAYS][256][4];
    logic [7:0] a_idx;
    logic [4:0] a_tg;
    logic [1:0] a_wd;
    assign a_idx = Addr[10:3];
    assign a_tg  = Addr[15:11];
    assign a_wd  = c_offset[2:1];

    always_comb begin
        c_tag_out  = '0;
        c_data_out = '0;
        c_valid    = '0;
        c_dirty    = '0;
        c_hit      = '0;
        for (int w = 0; w < WAYS; w++) begin
            c_tag_out[w*TAG_W +: TAG_W] = a_tag[w][a_idx];
            c_data_out[w*DW +: DW]      = a_data[w][a_idx][a_wd];
            c_valid[w] = a_val[w][a_idx];
            c_dirty[w] = a_dty[w][a_idx];
            c_hit[w]   = c_en[w] & c_comp & (a_tag[w][a_idx] == a_tg);
        end
    end

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < 256; s++) begin
                    a_tag[w][s] <= '0;
                    a_val[w][s] <= 1'b0;
                    a_dty[w][s] <= 1'b0;
                    for (int k = 0; k < 4; k++) a_data[w][s][k] <= '0;
                end
        end else begin
            for (int w = 0; w < WAYS; w++)
                if (c_en[w] && c_write) begin
                    if (c_comp) begin
                        if (a_val[w][a_idx] && a_tag[w][a_idx] == a_tg) begin
                            a_data[w][a_idx][a_wd] <= c_data_in;
                            a_dty[w][a_idx]        <= 1'b1;
                        end
                    end else begin
                        a_data[w][a_idx][a_wd] <= c_data_in;
                        a_tag[w][a_idx]        <= a_tg;
                        a_val[w][a_idx]        <= c_valid_in;
                        a_dty[w][a_idx]        <= 1'b0;
                    end
                end
        end
    end

    // ---------------- memory model: word at byte address A initialised to A ^ 0x1234 ----------------
    logic [DW-1:0] mem [32768];
    logic [14:0]   p_a [MEM_LAT];
    logic [32:0]   mlog[$];
    logic [32:0]   exp_log[$];
    assign m_data_out = mem[p_a[MEM_LAT-1]];

    always @(posedge clk) begin
        p_a[0] <= m_addr[15:1];
        for (int k = 1; k < MEM_LAT; k++) p_a[k] <= p_a[k-1];
        if (arr_clr) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 16'(2 * i) ^ 16'h1234;
        end else if (!rst && (m_rd || m_wr) && !m_stall) begin
            mlog.push_back({m_wr, m_addr, m_data_in});
            if (m_wr) mem[m_addr[15:1]] <= m_data_in;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] data;
        logic        chk_data;
        logic        hit;
        int          lat;
        int          t0;
    } exp_t;
    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every Done pops one expected response
    always @(negedge clk) begin
        exp_t e;
        if (!rst && Done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got Done=1 expected no Done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_stall", 64'(Stall), 64'(0));
                if (e.chk_data) chk("dataout", 64'(DataOut), 64'(e.data));
                chk("cachehit", 64'(CacheHit), 64'(e.hit));
                chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    function automatic void exp_fill(input logic [15:0] base);
        for (int k = 0; k < 4; k++) exp_log.push_back({1'b0, base + 16'(2 * k), 16'h0000});
    endfunction

    task automatic chk_traffic(input string name);
        chk({name, "_count"}, 64'(mlog.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < mlog.size(); i++)
            chk(name, 64'(mlog[i]), 64'(exp_log[i]));
        exp_log.delete();
    endtask

    task automatic req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                       input logic chk_data, input logic [15:0] exp_data, input logic exp_hit,
                       input int exp_lat, input int stall_at, input int stall_len,
                       input logic [15:0] stall_addr);
        exp_t e;
        bit seen;
        @(negedge clk);
        mlog.delete();
        e.data = exp_data; e.chk_data = chk_data; e.hit = exp_hit; e.lat = exp_lat; e.t0 = cyc;
        sb.push_back(e);
        Addr = a; DataIn = d; Rd = !wr; Wr = wr;
        seen = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (i == 1) begin Rd = 1'b0; Wr = 1'b0; end
            if (i == stall_at) m_stall = 1'b1;
            if (i == stall_at + stall_len) m_stall = 1'b0;
            if (stall_len > 0 && i >= stall_at && i < stall_at + stall_len) begin
                chk("stall_m_rd", 64'(m_rd), 64'(1));
                chk("stall_m_addr", 64'(m_addr), 64'(stall_addr));
            end
            if (Done) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL req_timeout: got no Done expected Done for addr %h", a);
            sb.delete();
            m_stall = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        rst = 1'b1; arr_clr = 1'b1;
        Addr = '0; DataIn = '0; Rd = 1'b0; Wr = 1'b0;
        m_stall = 1'b0; m_err = 1'b0; c_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({Stall, Done, CacheHit, err, c_en, c_comp, c_write, c_valid_in,
                                  m_rd, m_wr, m_addr, DataOut}), 64'(0));
        rst = 1'b0; arr_clr = 1'b0;
        @(negedge clk); #1;
        chk("idle_stall", 64'(Stall), 64'(0));

        // 1: cold read fills way0
        req(0, 16'h0010, 16'h0, 1, 16'h1224, 0, 9, 0, 0, 16'h0);
        exp_fill(16'h0010); chk_traffic("t1_fill");
        // 2: hit on same line, no memory traffic
        req(0, 16'h0012, 16'h0, 1, 16'h1226, 1, 2, 0, 0, 16'h0);
        chk_traffic("t2_hit");
        // 3: write hit dirties way0; tag B fills way1; tag C evicts dirty way0
        req(1, 16'h0010, 16'hBEEF, 0, 16'h0, 1, 2, 0, 0, 16'h0);
        chk_traffic("t3_wrhit");
        req(0, 16'h0810, 16'h0, 1, 16'h1A24, 0, 9, 0, 0, 16'h0);
        exp_fill(16'h0810); chk_traffic("t3_tagb");
        req(0, 16'h1010, 16'h0, 1, 16'h0224, 0, 13, 0, 0, 16'h0);
        exp_log.push_back({1'b1, 16'h0010, 16'hBEEF});
        exp_log.push_back({1'b1, 16'h0012, 16'h1226});
        exp_log.push_back({1'b1, 16'h0014, 16'h1220});
        exp_log.push_back({1'b1, 16'h0016, 16'h1222});
        exp_fill(16'h1010); chk_traffic("t3_tagc");
        req(0, 16'h0010, 16'h0, 1, 16'hBEEF, 0, 9, 0, 0, 16'h0);
        exp_fill(16'h0010); chk_traffic("t3_readback");

        // 4: three stall cycles in FILL while word 1 is pending
        req(0, 16'h0100, 16'h0, 1, 16'h1334, 0, 12, 3, 3, 16'h0102);
        exp_fill(16'h0100); chk_traffic("t4_fill");
        req(0, 16'h0106, 16'h0, 1, 16'h1332, 1, 2, 0, 0, 16'h0);
        req(0, 16'h0104, 16'h0, 1, 16'h1330, 1, 2, 0, 0, 16'h0);
        chk_traffic("t4_hits");

        // 5: illegal Rd&Wr and error pass-through
        @(negedge clk);
        mlog.delete();
        Rd = 1'b1; Wr = 1'b1;
        #1;
        chk("t5_err", 64'(err), 64'(1));
        chk("t5_stall", 64'(Stall), 64'(0));
        @(negedge clk); #1;
        chk("t5_idle", 64'({Stall, c_en, m_rd, m_wr}), 64'(0));
        Rd = 1'b0; Wr = 1'b0;
        #1;
        chk("t5_err_clear", 64'(err), 64'(0));
        m_err = 1'b1; #1;
        chk("t5_m_err", 64'(err), 64'(1));
        m_err = 1'b0; c_err = 1'b1; #1;
        chk("t5_c_err", 64'(err), 64'(1));
        c_err = 1'b0;
        chk_traffic("t5_traffic");

        // 6: build a dirty victim, reset in the middle of its write-back
        req(1, 16'h0200, 16'hCAFE, 0, 16'h0, 0, 9, 0, 0, 16'h0);
        exp_fill(16'h0200); chk_traffic("t6_wrmiss");
        req(0, 16'h0A00, 16'h0, 1, 16'h1834, 0, 9, 0, 0, 16'h0);
        exp_fill(16'h0A00); chk_traffic("t6_tagb");
        @(negedge clk);
        mlog.delete();
        Addr = 16'h1200; Rd = 1'b1;
        @(negedge clk); #1;
        Rd = 1'b0;
        @(negedge clk); #1;
        chk("t6_wb_word0", 64'({m_wr, m_addr, m_data_in}), 64'({1'b1, 16'h0200, 16'hCAFE}));
        @(negedge clk); #1;
        chk("t6_wb_word1_addr", 64'(m_addr), 64'(16'h0202));
        rst = 1'b1;
        #1;
        chk("t6_reset_outputs", 64'({Stall, Done, CacheHit, err, c_en, c_comp, c_write, c_valid_in,
                                     m_rd, m_wr, m_addr, DataOut}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (15) begin
            @(negedge clk); #1;
            if (Done) dn++;
        end
        chk("t6_no_done", 64'(dn), 64'(0));
        exp_log.push_back({1'b1, 16'h0200, 16'hCAFE});
        chk_traffic("t6_abandoned");
        req(0, 16'h0202, 16'h0, 1, 16'h1036, 1, 2, 0, 0, 16'h0);
        chk_traffic("t6_hit_after_reset");
        req(0, 16'h1200, 16'h0, 1, 16'h0034, 0, 9, 0, 0, 16'h0);
        exp_fill(16'h1200); chk_traffic("t6_miss_after_reset");

        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
